serializer_stream: RTL

Parametrised successor to the team's fixed 16-bit serializer. It converts DATA_W-bit parallel words into a serial bit stream, with a per-word bit count and a per-word bit order. Both sides use valid/ready handshakes, and a one-word prefetch buffer lets consecutive words stream with no idle cycles. It sits between the word-oriented datapath and a bit-serial line interface that may stall.

---
 rtl/serializer_stream_if.sv | 26 ++
 rtl/serializer_stream.sv | 64 ++++++
 2 files changed

// File: rtl/serializer_stream_if.sv
// serializer_stream_if: word-in / bit-out handshake bundle for serializer_stream
// Signals: data_i/data_mod_i/data_lsb_first_i/data_val_i/data_rdy_o word side,
//          ser_data_o/ser_data_val_o/ser_last_o/ser_data_rdy_i bit side.
// Modports: master drives words and accepts bits, slave is the serializer.
interface serializer_stream_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W = $clog2(DATA_W)
);
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0] data_mod_i;
  logic data_lsb_first_i;
  logic data_val_i;
  logic data_rdy_o;
  logic ser_data_o;
  logic ser_data_val_o;
  logic ser_last_o;
  logic ser_data_rdy_i;
  modport master (
    output data_i, data_mod_i, data_lsb_first_i, data_val_i, ser_data_rdy_i,
    input  data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o
  );
  modport slave (
    input  data_i, data_mod_i, data_lsb_first_i, data_val_i, ser_data_rdy_i,
    output data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o
  );
endinterface

// File: rtl/serializer_stream.sv
// serializer_stream: DATA_W-bit words to a serial bit stream with per-word length and bit order
// Ports: clk_i clock, arstn_i async active-low reset,
//        s word-in/bit-out handshake bundle (slave), busy_o buffer or engine occupied.
module serializer_stream #(
  parameter int DATA_W = 16,
  parameter int MIN_BITS = 3,
  parameter int MOD_W = $clog2(DATA_W)
) (
  input  logic clk_i,
  input  logic arstn_i,
  serializer_stream_if.slave s,
  output logic busy_o
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [DATA_W-1:0] sh, bw, rev, in_word;
  logic [MOD_W:0] cnt, bc, in_cnt;
  logic bf, drop, acc, xfer, fin, free;
  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign rev[i] = s.data_i[DATA_W-1-i];
  end
  // LSB-first words are bit-reversed on entry so the engine always shifts out of the MSB
  assign in_word = s.data_lsb_first_i ? rev : s.data_i;
  // counter holds bits remaining after the current one
  assign in_cnt = s.data_mod_i == '0 ? (MOD_W+1)'(DATA_W-1) : {1'b0, s.data_mod_i} - 1'b1;
  assign drop = s.data_mod_i != '0 && {1'b0, s.data_mod_i} < (MOD_W+1)'(MIN_BITS);
  assign acc = s.data_val_i && !bf && !drop;
  assign xfer = state == SHIFT && s.ser_data_rdy_i;
  assign fin = xfer && cnt == '0;
  assign free = state == IDLE || fin;
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      bw <= '0;
      bc <= '0;
      bf <= 1'b0;
    end else begin
      if (fin && bf) begin
        sh <= bw;
        cnt <= bc;
        bf <= 1'b0;
      end else if (acc && free) begin
        sh <= in_word;
        cnt <= in_cnt;
        state <= SHIFT;
      end else if (xfer) begin
        sh <= sh << 1;
        cnt <= cnt - 1'b1;
        if (fin) state <= IDLE;
      end
      if (acc && !free) begin
        bw <= in_word;
        bc <= in_cnt;
        bf <= 1'b1;
      end
    end
  assign s.data_rdy_o = !bf;
  assign s.ser_data_o = sh[DATA_W-1];
  assign s.ser_data_val_o = state == SHIFT;
  assign s.ser_last_o = state == SHIFT && cnt == '0;
  assign busy_o = state == SHIFT || bf;
endmodule
